// File: rtl/conv_mac_layer_p.sv
// -----------------------------------------------------------------------------
// conv_mac_layer_p
// Streaming convolution layer. Each accepted sample (Start=1) multiplies
// Image by Filter and adds the product to a running window accumulator. After
// KERNEL_LEN taps the window sum is stored in a NUM_OUT-entry result buffer.
// Once every entry is stored the block is Full and drains one result per
// ReadEn cycle. It then returns to idle, ready for the next pass.
//
// Parameters
//   DATA_W     : width of Image / Filter samples
//   KERNEL_LEN : taps per output window (>= 1)
//   NUM_OUT    : output windows per pass (>= 1)
//   SIGNED     : 1 = two's complement operands and results, 0 = unsigned
//   RELU       : 1 = negative results read back as 0 (signed mode only)
//   OUT_W      : derived result width, 2*DATA_W + max(1, clog2(KERNEL_LEN))
//
// Ports
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   Start       : sample qualifier, Image/Filter consumed when high
//   Image       : image sample
//   Filter      : filter coefficient
//   ReadEn      : read request, honoured only while Full
//   ConvResult  : registered read-out value
//   ResultValid : high for the cycle after an accepted read
//   Busy        : block is accumulating or holding results
//   Full        : all results stored, draining
// -----------------------------------------------------------------------------
module conv_mac_layer_p #(
    parameter int DATA_W     = 4,
    parameter int KERNEL_LEN = 3,
    parameter int NUM_OUT    = 5,
    parameter int SIGNED     = 0,
    parameter int RELU       = 0,
    localparam int LOG_K     = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1,
    localparam int OUT_W     = 2 * DATA_W + LOG_K
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic [DATA_W-1:0] Image,
    input  logic [DATA_W-1:0] Filter,
    input  logic              ReadEn,
    output logic [OUT_W-1:0]  ConvResult,
    output logic              ResultValid,
    output logic              Busy,
    output logic              Full
);

    localparam int PW    = 2 * DATA_W;
    localparam int TAP_W = LOG_K;
    localparam int PTR_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KERNEL_LEN - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [OUT_W-1:0]   res_q, res_d;
    logic               valid_q, valid_d;

    logic [OUT_W-1:0]   buf_mem [NUM_OUT];
    logic               buf_we;
    logic [OUT_W-1:0]   sum;
    logic [OUT_W-1:0]   rd_val;

    logic [PW-1:0]      img_x, flt_x, prod;
    logic [OUT_W-1:0]   prod_ext;

    // Operands are widened to 2*DATA_W before multiplying, so the low
    // 2*DATA_W bits of the unsigned product equal the true (signed or
    // unsigned) product. The product is then extended to the accumulator width.
    generate
        if (SIGNED != 0) begin : g_signed
            assign img_x    = {{DATA_W{Image[DATA_W-1]}}, Image};
            assign flt_x    = {{DATA_W{Filter[DATA_W-1]}}, Filter};
            assign prod_ext = {{LOG_K{prod[PW-1]}}, prod};
        end else begin : g_unsigned
            assign img_x    = {{DATA_W{1'b0}}, Image};
            assign flt_x    = {{DATA_W{1'b0}}, Filter};
            assign prod_ext = {{LOG_K{1'b0}}, prod};
        end
    endgenerate

    assign prod = img_x * flt_x;
    assign sum  = acc_q + prod_ext;

    assign rd_val = buf_mem[rd_q];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tap_d   = tap_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        res_d   = res_q;
        valid_d = 1'b0;
        buf_we  = 1'b0;

        case (state_q)
            // IDLE and ACCUM take samples the same way. The first sample out
            // of IDLE is simply tap 0 of the first window.
            IDLE, ACCUM: begin
                if (Start) begin
                    state_d = ACCUM;
                    if (tap_q == TAP_LAST) begin
                        buf_we = 1'b1;
                        acc_d  = '0;
                        tap_d  = '0;
                        wr_d   = wr_q + 1'b1;
                        if (wr_q == PTR_LAST) begin
                            state_d = FULL;
                        end
                    end else begin
                        acc_d = sum;
                        tap_d = tap_q + 1'b1;
                    end
                end
            end

            // Start is ignored here. Samples offered while draining are dropped.
            FULL: begin
                if (ReadEn) begin
                    valid_d = 1'b1;
                    if ((RELU != 0) && (SIGNED != 0) && rd_val[OUT_W-1]) begin
                        res_d = '0;
                    end else begin
                        res_d = rd_val;
                    end
                    if (rd_q == PTR_LAST) begin
                        state_d = IDLE;
                        wr_d    = '0;
                        rd_d    = '0;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            tap_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tap_q   <= tap_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    // Result storage carries no reset. Stale contents are never read, because
    // reads are only honoured after every entry of the pass has been written.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[wr_q] <= sum;
        end
    end

    assign ConvResult  = res_q;
    assign ResultValid = valid_q;
    assign Busy        = (state_q != IDLE);
    assign Full        = (state_q == FULL);

endmodule

// File: tb/tb_conv_mac_layer_p.sv
module tb_conv_mac_layer_p;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Default instance (unsigned, 4-bit, 3 taps, 5 outputs)
    logic       s0 = 1'b0, rd0 = 1'b0;
    logic [3:0] img0 = '0, flt0 = '0;
    logic [9:0] res0;
    logic       v0, b0, f0;
    conv_mac_layer_p dut0 (
        .clk(clk), .rst(rst), .Start(s0), .Image(img0), .Filter(flt0),
        .ReadEn(rd0), .ConvResult(res0), .ResultValid(v0), .Busy(b0), .Full(f0)
    );

    // Signed single-output instances, with and without ReLU, sharing stimulus
    logic       s1 = 1'b0, rd1 = 1'b0;
    logic [3:0] img1 = '0, flt1 = '0;
    logic [9:0] res1, res2;
    logic       v1, b1, f1, v2, b2, f2;
    conv_mac_layer_p #(.SIGNED(1), .NUM_OUT(1)) dut1 (
        .clk(clk), .rst(rst), .Start(s1), .Image(img1), .Filter(flt1),
        .ReadEn(rd1), .ConvResult(res1), .ResultValid(v1), .Busy(b1), .Full(f1)
    );
    conv_mac_layer_p #(.SIGNED(1), .RELU(1), .NUM_OUT(1)) dut2 (
        .clk(clk), .rst(rst), .Start(s1), .Image(img1), .Filter(flt1),
        .ReadEn(rd1), .ConvResult(res2), .ResultValid(v2), .Busy(b2), .Full(f2)
    );

    // Wide instance
    logic        s3 = 1'b0, rd3 = 1'b0;
    logic [7:0]  img3 = '0, flt3 = '0;
    logic [19:0] res3;
    logic        v3, b3, f3;
    conv_mac_layer_p #(.DATA_W(8), .KERNEL_LEN(9), .NUM_OUT(4)) dut3 (
        .clk(clk), .rst(rst), .Start(s3), .Image(img3), .Filter(flt3),
        .ReadEn(rd3), .ConvResult(res3), .ResultValid(v3), .Busy(b3), .Full(f3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- reference model for dut0 ----------------
    // Window sums are queued as they complete. Full means five results are
    // queued and not yet all read out.
    int  m_acc = 0;
    int  m_taps = 0;
    int  m_q[$];
    bit  m_full = 1'b0;
    int  m_last = 0;

    task automatic model_clear();
        m_acc = 0; m_taps = 0; m_q.delete(); m_full = 1'b0; m_last = 0;
    endtask

    // One clock of dut0: drive at negedge, let the posedge act, check at next negedge.
    task automatic cyc0(input bit st, input int im, input int fl, input bit rd);
        bit exp_v;
        s0 = st; img0 = im[3:0]; flt0 = fl[3:0]; rd0 = rd;
        @(negedge clk);
        exp_v = 1'b0;
        if (m_full) begin
            if (rd) begin
                exp_v  = 1'b1;
                m_last = m_q.pop_front();
                if (m_q.size() == 0) m_full = 1'b0;
            end
        end else if (st) begin
            m_acc += im * fl;
            m_taps++;
            if (m_taps == 3) begin
                m_q.push_back(m_acc);
                m_acc  = 0;
                m_taps = 0;
                if (m_q.size() == 5) m_full = 1'b1;
            end
        end
        check("valid0", 32'(v0), 32'(exp_v));
        check("result0", 32'(res0), m_last);
        check("full0", 32'(f0), 32'(m_full));
        check("busy0", 32'(b0), 32'(m_full || m_taps != 0 || m_q.size() != 0));
        s0 = 1'b0; rd0 = 1'b0;
    endtask

    // Test-plan window w, tap t: Image = w+t+1, Filter = t+1
    task automatic plan_samples(input int first, input int count);
        for (int n = first; n < first + count; n++) begin
            cyc0(1'b1, n / 3 + n % 3 + 1, n % 3 + 1, 1'b0);
        end
    endtask

    task automatic reset_mid();
        #2 rst = 1'b1;
        #1;
        check("rst_result", 32'(res0), 0);
        check("rst_valid", 32'(v0), 0);
        check("rst_busy", 32'(b0), 0);
        check("rst_full", 32'(f0), 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- signed table ----------------
    typedef struct {
        logic [3:0] i0, i1, i2, f0, f1, f2;
        int         exp_s;
        int         exp_r;
    } vec_t;

    function automatic vec_t mk(input int a0, input int a1, input int a2,
                                input int c0, input int c1, input int c2,
                                input int es, input int er);
        vec_t v;
        v.i0 = a0[3:0]; v.i1 = a1[3:0]; v.i2 = a2[3:0];
        v.f0 = c0[3:0]; v.f1 = c1[3:0]; v.f2 = c2[3:0];
        v.exp_s = es; v.exp_r = er;
        return v;
    endfunction

    task automatic feed1(input logic [3:0] a, input logic [3:0] c);
        s1 = 1'b1; img1 = a; flt1 = c;
        @(negedge clk);
        s1 = 1'b0;
    endtask

    // Three taps then one read on dut1/dut2, checking both results.
    task automatic signed_window(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                                 input logic [3:0] a2, input logic [3:0] c0,
                                 input logic [3:0] c1, input logic [3:0] c2,
                                 input int es, input int er);
        logic [9:0] e_s, e_r;
        e_s = es[9:0];
        e_r = er[9:0];
        feed1(a0, c0);
        feed1(a1, c1);
        feed1(a2, c2);
        check({tag, "_full"}, 32'(f1), 1);
        rd1 = 1'b1;
        @(negedge clk);
        rd1 = 1'b0;
        check({tag, "_valid_s"}, 32'(v1), 1);
        check({tag, "_res_s"}, 32'(res1), 32'(e_s));
        check({tag, "_valid_r"}, 32'(v2), 1);
        check({tag, "_res_r"}, 32'(res2), 32'(e_r));
        check({tag, "_idle"}, 32'(f1 | b1), 0);
    endtask

    function automatic int sx4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    vec_t tbl[6];

    initial begin
        int  cnt;
        bit  saw_full, done;

        tbl[0] = mk(-1, -2, -3,  1,  2,  3, -14,   0);
        tbl[1] = mk(-8, -8, -8, -8, -8, -8, 192, 192);
        tbl[2] = mk( 1,  2,  3,  1,  2,  3,  14,  14);
        tbl[3] = mk( 7,  7,  7, -8, -8, -8, -168,  0);
        tbl[4] = mk( 7,  7,  7,  7,  7,  7, 147, 147);
        tbl[5] = mk( 0,  0,  0,  5, -3,  2,   0,   0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_result", 32'(res0), 0);
        check("reset_valid", 32'(v0), 0);
        check("reset_busy", 32'(b0), 0);
        check("reset_full", 32'(f0), 0);
        check("reset_wide_result", 32'(res3), 0);

        // ---- Basic pass: Full on the 15th edge, 7 read cycles ----
        plan_samples(0, 14);
        check("plan_full_before_15", 32'(f0), 0);
        plan_samples(14, 1);
        check("plan_full_at_15", 32'(f0), 1);
        for (int i = 0; i < 7; i++) begin
            cyc0(1'b0, 0, 0, 1'b1);
            if (i < 5) begin
                check("plan_read_valid", 32'(v0), 1);
                check("plan_read_value", 32'(res0), 32'(14 + 6 * i));
            end else begin
                check("plan_extra_valid", 32'(v0), 0);
                check("plan_extra_hold", 32'(res0), 38);
            end
        end
        check("plan_after_full", 32'(f0), 0);
        check("plan_after_busy", 32'(b0), 0);

        // ---- Pause between taps 2 and 3, ReadEn pulse while accumulating ----
        cyc0(1'b1, 1, 1, 1'b0);
        cyc0(1'b1, 2, 2, 1'b0);
        cyc0(1'b0, 0, 0, 1'b1);
        check("pause_read_ignored", 32'(v0), 0);
        check("pause_busy", 32'(b0), 1);
        cyc0(1'b0, 9, 9, 1'b0);
        cyc0(1'b1, 3, 3, 1'b0);
        plan_samples(3, 12);
        cyc0(1'b0, 0, 0, 1'b1);
        check("pause_buf0", 32'(res0), 14);
        for (int i = 0; i < 4; i++) cyc0(1'b0, 0, 0, 1'b1);

        // ---- Reset after 7 samples, then a clean pass ----
        plan_samples(0, 7);
        reset_mid();
        plan_samples(0, 15);
        for (int i = 0; i < 5; i++) begin
            cyc0(1'b0, 0, 0, 1'b1);
            check("post_rst_read", 32'(res0), 32'(14 + 6 * i));
        end

        // ---- Start with 15*15 offered during every read ----
        plan_samples(0, 15);
        for (int i = 0; i < 5; i++) begin
            cyc0(1'b1, 15, 15, 1'b1);
            check("contention_read", 32'(res0), 32'(14 + 6 * i));
        end
        check("contention_idle", 32'(b0), 0);
        plan_samples(0, 15);
        cyc0(1'b0, 0, 0, 1'b1);
        check("contention_next_wr0", 32'(res0), 14);
        for (int i = 0; i < 4; i++) cyc0(1'b0, 0, 0, 1'b1);

        // ---- Randomised passes with gaps and stray reads ----
        for (int p = 0; p < 12; p++) begin
            cnt = 0; saw_full = 1'b0; done = 1'b0;
            while (!done && cnt < 300) begin
                cyc0(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
                cnt++;
                if (m_full) saw_full = 1'b1;
                if (saw_full && !m_full) done = 1'b1;
            end
            check("rand0_drained", 32'(done), 1);
        end

        // ---- Signed / ReLU table ----
        for (int k = 0; k < 6; k++) begin
            signed_window("tbl", tbl[k].i0, tbl[k].i1, tbl[k].i2,
                          tbl[k].f0, tbl[k].f1, tbl[k].f2, tbl[k].exp_s, tbl[k].exp_r);
        end

        // ---- Signed random windows against plain signed arithmetic ----
        for (int k = 0; k < 20; k++) begin
            int a[3], c[3], sum;
            sum = 0;
            for (int t = 0; t < 3; t++) begin
                a[t] = int'($urandom_range(0, 15));
                c[t] = int'($urandom_range(0, 15));
                sum += sx4(a[t]) * sx4(c[t]);
            end
            signed_window("srand", a[0][3:0], a[1][3:0], a[2][3:0],
                          c[0][3:0], c[1][3:0], c[2][3:0], sum, (sum < 0) ? 0 : sum);
        end

        // ---- Wide instance: all operands 255 ----
        for (int n = 0; n < 36; n++) begin
            s3 = 1'b1; img3 = 8'hFF; flt3 = 8'hFF;
            @(negedge clk);
        end
        s3 = 1'b0;
        check("wide_full", 32'(f3), 1);
        for (int i = 0; i < 5; i++) begin
            rd3 = 1'b1;
            @(negedge clk);
            if (i < 4) begin
                check("wide_valid", 32'(v3), 1);
                check("wide_value", 32'(res3), 585225);
            end else begin
                check("wide_extra_valid", 32'(v3), 0);
            end
        end
        rd3 = 1'b0;
        check("wide_idle", 32'(b3), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
